exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_exec_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - MIPS-subset execution unit with iterative MULTU and valid/ready handshake
// Single-cycle ALU/memory/branch ops; MULTU runs one shift-add step per cycle.
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        operation_code,
  input  logic [5:0]        function_code,
  input  logic [15:0]       immediate_value,
  input  logic [DATA_W-1:0] register_source_value,
  input  logic [DATA_W-1:0] register_target_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] execution_result,
  output logic              result_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] store_data,
  output logic              illegal,
  output logic [PC_W-1:0]   program_counter
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              we_q, we_d, rd_q, rd_d, wr_q, wr_d, ill_q, ill_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] rs, rt, ext_imm, addr, mul_sum;
  logic [PC_W-1:0]   br_off;
  logic [DATA_W-1:0] dec_res;
  logic [PC_W-1:0]   dec_pc;
  logic              dec_we, dec_rd, dec_wr, dec_ill, dec_mul;

  assign rs      = register_source_value;
  assign rt      = register_target_value;
  assign ext_imm = DATA_W'($signed(immediate_value));
  assign br_off  = PC_W'($signed(immediate_value));
  assign addr    = rs + ext_imm;
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    dec_res = '0;
    dec_pc  = pc_q + PC_W'(1);
    dec_we  = 1'b0;
    dec_rd  = 1'b0;
    dec_wr  = 1'b0;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    case (operation_code)
      6'h00: begin
        dec_we = 1'b1;
        case (function_code)
          6'h21: dec_res = rs + rt;
          6'h23: dec_res = rs - rt;
          6'h24: dec_res = rs & rt;
          6'h25: dec_res = rs | rt;
          6'h2A: dec_res = DATA_W'($signed(rs) < $signed(rt));
          6'h2B: dec_res = DATA_W'(rs < rt);
          6'h19: begin
            if (MUL_EN != 0) begin
              dec_mul = 1'b1;
            end else begin
              dec_we  = 1'b0;
              dec_ill = 1'b1;
            end
          end
          default: begin
            dec_we  = 1'b0;
            dec_ill = 1'b1;
          end
        endcase
      end
      6'h09: begin dec_res = addr; dec_we = 1'b1; end
      6'h23: begin dec_res = addr; dec_we = 1'b1; dec_rd = 1'b1; end
      6'h2B: begin dec_res = addr; dec_wr = 1'b1; end
      6'h04: if (rs == rt) dec_pc = pc_q + br_off;
      6'h05: if (rs != rt) dec_pc = pc_q + br_off;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    result_d = result_q;
    store_d  = store_q;
    we_d     = we_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          we_d    = dec_we;
          rd_d    = dec_rd;
          wr_d    = dec_wr;
          ill_d   = dec_ill;
          store_d = dec_wr ? rt : '0;
          if (dec_mul) begin
            state_d  = S_MUL;
            mcand_d  = rs;
            mplier_d = rt;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = S_DONE;
            result_d = dec_res;
            pc_d     = dec_pc;
          end
        end
      end
      S_MUL: begin
        // Final partial product folds straight into the result on the DONE edge.
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = mul_sum;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = S_DONE;
          result_d = mul_sum;
          pc_d     = pc_q + PC_W'(1);
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      result_q <= '0;
      store_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      store_q  <= store_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_DONE);
  assign result_we        = we_q & out_valid;
  assign mem_rd           = rd_q & out_valid;
  assign mem_wr           = wr_q & out_valid;
  assign illegal          = ill_q & out_valid;
  assign execution_result = result_q;
  assign store_data       = store_q;
  assign program_counter  = pc_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit (DATA_W=8, PC_W=8)
// Directed scenarios plus randomized instructions against an arithmetic reference model.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  operation_code = '0;
  logic [5:0]  function_code = '0;
  logic [15:0] immediate_value = '0;
  logic [7:0]  register_source_value = '0;
  logic [7:0]  register_target_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  execution_result;
  logic        result_we, mem_rd, mem_wr, illegal;
  logic [7:0]  store_data;
  logic [7:0]  program_counter;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_pc;

  typedef struct {
    int         lat;
    logic [7:0] res, sd, pc;
    logic       we, rd, wr, ill;
    bit         stable, busy_ok, timeout, released;
  } obs_t;

  typedef struct {
    int         lat;
    logic [7:0] res, pc;
    bit         we, rd, wr, ill, sw;
    logic [7:0] sd;
  } exp_t;

  exec_unit #(.DATA_W(8), .PC_W(8), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation_code(operation_code), .function_code(function_code),
    .immediate_value(immediate_value),
    .register_source_value(register_source_value),
    .register_target_value(register_target_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .execution_result(execution_result), .result_we(result_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .store_data(store_data),
    .illegal(illegal), .program_counter(program_counter)
  );

  always #5 clk = ~clk;

  function automatic int sgn8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                                 input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] pc);
    exp_t e;
    int a, b, im;
    a = int'(rs); b = int'(rt); im = int'(imm) % 256;
    e = '{default: 0};
    e.lat = 1;
    e.pc  = 8'((int'(pc) + 1) % 256);
    if (op == 6'h00 && fn == 6'h21) begin e.res = 8'((a + b) % 256); e.we = 1; end
    else if (op == 6'h00 && fn == 6'h23) begin e.res = 8'((a - b + 256) % 256); e.we = 1; end
    else if (op == 6'h00 && fn == 6'h24) begin e.res = rs & rt; e.we = 1; end
    else if (op == 6'h00 && fn == 6'h25) begin e.res = rs | rt; e.we = 1; end
    else if (op == 6'h00 && fn == 6'h2A) begin e.res = (sgn8(a) < sgn8(b)) ? 8'd1 : 8'd0; e.we = 1; end
    else if (op == 6'h00 && fn == 6'h2B) begin e.res = (a < b) ? 8'd1 : 8'd0; e.we = 1; end
    else if (op == 6'h00 && fn == 6'h19) begin e.res = 8'((a * b) % 256); e.we = 1; e.lat = 9; end
    else if (op == 6'h09) begin e.res = 8'((a + im) % 256); e.we = 1; end
    else if (op == 6'h23) begin e.res = 8'((a + im) % 256); e.we = 1; e.rd = 1; end
    else if (op == 6'h2B) begin e.res = 8'((a + im) % 256); e.wr = 1; e.sw = 1; e.sd = rt; end
    else if (op == 6'h04) begin if (a == b) e.pc = 8'((int'(pc) + im) % 256); end
    else if (op == 6'h05) begin if (a != b) e.pc = 8'((int'(pc) + im) % 256); end
    else e.ill = 1;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_pc = 8'h00;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm,
                           input logic [7:0] rs, input logic [7:0] rt, input int hold,
                           input bit early, output obs_t o);
    int n;
    o = '{default: 0};
    o.stable = 1; o.busy_ok = 1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) o.timeout = 1;
    operation_code = op; function_code = fn; immediate_value = imm;
    register_source_value = rs; register_target_value = rt;
    in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    o.lat = 1;
    while (out_valid !== 1'b1 && o.lat < 40) begin
      if (in_ready !== 1'b0) o.busy_ok = 0;
      @(posedge clk); #1;
      o.lat++;
    end
    if (out_valid !== 1'b1) o.timeout = 1;
    if (in_ready !== 1'b0) o.busy_ok = 0;
    o.res = execution_result; o.sd = store_data; o.pc = program_counter;
    o.we = result_we; o.rd = mem_rd; o.wr = mem_wr; o.ill = illegal;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || execution_result !== o.res ||
            store_data !== o.sd || program_counter !== o.pc || result_we !== o.we ||
            mem_rd !== o.rd || mem_wr !== o.wr || illegal !== o.ill) o.stable = 0;
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    o.released = (out_valid === 1'b0 && in_ready === 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    if (program_counter !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", program_counter); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if ({execution_result, store_data} !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h/%h exp=00/00", execution_result, store_data); end
    checks++;
    if ({result_we, mem_rd, mem_wr, illegal} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {result_we, mem_rd, mem_wr, illegal}); end
    checks++;
  endtask

  task automatic test_addu();
    obs_t o;
    run_instr(6'h00, 6'h21, 16'h0000, 8'hF0, 8'h20, 0, 0, o);
    if (o.lat !== 1 || o.timeout) begin failures++; $display("FAIL addu_latency got=%0d exp=1", o.lat); end
    checks++;
    if (o.res !== 8'h10) begin failures++; $display("FAIL addu_result got=%h exp=10", o.res); end
    checks++;
    if (o.we !== 1'b1) begin failures++; $display("FAIL addu_we got=%b exp=1", o.we); end
    checks++;
    if (o.pc !== 8'h01) begin failures++; $display("FAIL addu_pc got=%h exp=01", o.pc); end
    checks++;
    if (!o.released) begin failures++; $display("FAIL addu_release got=0 exp=1"); end
    checks++;
    exp_pc = 8'h01;
  endtask

  task automatic test_slt();
    obs_t o;
    run_instr(6'h00, 6'h2A, 16'h0000, 8'h80, 8'h01, 0, 0, o);
    if (o.res !== 8'h01) begin failures++; $display("FAIL slt_result got=%h exp=01", o.res); end
    checks++;
    run_instr(6'h00, 6'h2B, 16'h0000, 8'h80, 8'h01, 1, 0, o);
    if (o.res !== 8'h00) begin failures++; $display("FAIL sltu_result got=%h exp=00", o.res); end
    checks++;
    exp_pc = exp_pc + 8'd2;
  endtask

  task automatic test_branch();
    obs_t o;
    do_reset();
    repeat (5) run_instr(6'h00, 6'h25, 16'h0000, 8'h01, 8'h02, 0, 0, o);
    if (o.pc !== 8'h05) begin failures++; $display("FAIL branch_setup_pc got=%h exp=05", o.pc); end
    checks++;
    run_instr(6'h04, 6'h00, 16'hFFFE, 8'h33, 8'h33, 0, 0, o);
    if (o.pc !== 8'h03) begin failures++; $display("FAIL beq_taken_pc got=%h exp=03", o.pc); end
    checks++;
    if (o.we !== 1'b0 || o.ill !== 1'b0) begin failures++; $display("FAIL beq_flags got=%b%b exp=00", o.we, o.ill); end
    checks++;
    repeat (2) run_instr(6'h00, 6'h24, 16'h0000, 8'h0F, 8'hF0, 0, 0, o);
    run_instr(6'h05, 6'h00, 16'hFFFE, 8'h33, 8'h33, 0, 0, o);
    if (o.pc !== 8'h06) begin failures++; $display("FAIL bne_not_taken_pc got=%h exp=06", o.pc); end
    checks++;
    exp_pc = 8'h06;
  endtask

  task automatic test_multu();
    obs_t o;
    run_instr(6'h00, 6'h19, 16'h0000, 8'h0D, 8'h0B, 3, 0, o);
    if (o.lat !== 9 || o.timeout) begin failures++; $display("FAIL multu_latency got=%0d exp=9", o.lat); end
    checks++;
    if (o.res !== 8'h8F) begin failures++; $display("FAIL multu_result got=%h exp=8F", o.res); end
    checks++;
    if (!o.stable) begin failures++; $display("FAIL multu_hold_stable got=0 exp=1"); end
    checks++;
    if (!o.busy_ok) begin failures++; $display("FAIL multu_in_ready_low got=0 exp=1"); end
    checks++;
    exp_pc = exp_pc + 8'd1;
    if (o.pc !== exp_pc) begin failures++; $display("FAIL multu_pc got=%h exp=%h", o.pc, exp_pc); end
    checks++;
  endtask

  task automatic test_reset_mid_mul();
    obs_t o;
    bit   seen;
    operation_code = 6'h00; function_code = 6'h19;
    register_source_value = 8'hFF; register_target_value = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midmul_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (program_counter !== 8'h00) begin failures++; $display("FAIL midmul_pc got=%h exp=00", program_counter); end
    checks++;
    @(posedge clk); #1 rst = 1'b0;
    exp_pc = 8'h00;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midmul_in_ready got=%b exp=1", in_ready); end
    checks++;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid !== 1'b0 || program_counter !== 8'h00) seen = 1; end
    if (seen) begin failures++; $display("FAIL midmul_discard got=1 exp=0"); end
    checks++;
    run_instr(6'h2B, 6'h00, 16'h0004, 8'h10, 8'hAA, 1, 0, o);
    if (o.res !== 8'h14 || o.sd !== 8'hAA) begin failures++; $display("FAIL sw_data got=%h/%h exp=14/AA", o.res, o.sd); end
    checks++;
    if (o.wr !== 1'b1 || o.we !== 1'b0 || o.rd !== 1'b0) begin failures++; $display("FAIL sw_flags got=%b%b%b exp=100", o.wr, o.we, o.rd); end
    checks++;
    exp_pc = 8'h01;
  endtask

  task automatic test_illegal();
    obs_t o;
    run_instr(6'h3F, 6'h00, 16'h1234, 8'h55, 8'h66, 0, 0, o);
    if (o.ill !== 1'b1 || o.res !== 8'h00 || {o.we, o.rd, o.wr} !== 3'b000) begin
      failures++; $display("FAIL illegal_op got=ill%b res%h f%b%b%b exp=ill1 res00 f000", o.ill, o.res, o.we, o.rd, o.wr);
    end
    checks++;
    run_instr(6'h00, 6'h18, 16'h0000, 8'h55, 8'h66, 0, 0, o);
    exp_pc = exp_pc + 8'd2;
    if (o.ill !== 1'b1 || o.pc !== exp_pc) begin failures++; $display("FAIL illegal_funct got=ill%b pc%h exp=ill1 pc%h", o.ill, o.pc, exp_pc); end
    checks++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    operation_code = 6'h00; function_code = 6'h19;
    register_source_value = 8'h07; register_target_value = 8'h06;
    in_valid = 1'b1;
    @(posedge clk); #1;
    register_source_value = 8'h11; register_target_value = 8'h22;
    function_code = 6'h21;
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (n !== 9 || execution_result !== 8'h2A) begin failures++; $display("FAIL b2b_first got=lat%0d res%h exp=lat9 res2A", n, execution_result); end
    checks++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ok = (in_ready === 1'b1 && out_valid === 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok || out_valid !== 1'b1 || execution_result !== 8'h33) begin
      failures++; $display("FAIL b2b_second got=ok%0d v%b res%h exp=ok1 v1 res33", ok, out_valid, execution_result);
    end
    checks++;
    exp_pc = exp_pc + 8'd2;
    if (program_counter !== exp_pc) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", program_counter, exp_pc); end
    checks++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h00};
    logic [5:0] fns [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h19, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};
    obs_t o;
    exp_t e;
    for (int t = 0; t < 150; t++) begin
      int k;
      logic [5:0]  op, fn;
      logic [15:0] imm;
      logic [7:0]  rs, rt;
      bit          early;
      k   = $urandom_range(0, 13);
      op  = ops[k]; fn = fns[k];
      if (k == 12) op = 6'(2 + $urandom_range(0, 1) * 13);
      imm = 16'($urandom);
      rs  = 8'($urandom);
      rt  = ($urandom_range(0, 3) == 0) ? rs : 8'($urandom);
      early = ($urandom_range(0, 3) == 0);
      e = model(op, fn, imm, rs, rt, exp_pc);
      run_instr(op, fn, imm, rs, rt, $urandom_range(0, 2), early, o);
      exp_pc = e.pc;
      if (o.timeout || o.lat !== e.lat) begin failures++; $display("FAIL rnd%0d_latency op=%h fn=%h got=%0d exp=%0d", t, op, fn, o.lat, e.lat); end
      checks++;
      if (o.res !== e.res && !(op == 6'h04 || op == 6'h05)) begin failures++; $display("FAIL rnd%0d_result op=%h fn=%h got=%h exp=%h", t, op, fn, o.res, e.res); end
      checks++;
      if ({o.we, o.rd, o.wr, o.ill} !== {e.we, e.rd, e.wr, e.ill}) begin
        failures++; $display("FAIL rnd%0d_flags op=%h fn=%h got=%b%b%b%b exp=%b%b%b%b", t, op, fn, o.we, o.rd, o.wr, o.ill, e.we, e.rd, e.wr, e.ill);
      end
      checks++;
      if (o.pc !== e.pc) begin failures++; $display("FAIL rnd%0d_pc op=%h got=%h exp=%h", t, op, o.pc, e.pc); end
      checks++;
      if (e.sw && o.sd !== e.sd) begin failures++; $display("FAIL rnd%0d_store_data got=%h exp=%h", t, o.sd, e.sd); end
      checks++;
      if (!o.stable || !o.busy_ok || !o.released) begin
        failures++; $display("FAIL rnd%0d_handshake got=stable%0d busy%0d rel%0d exp=111", t, o.stable, o.busy_ok, o.released);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_slt();
    test_branch();
    test_multu();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
